// File: rtl/regs_dump_if.sv
// Signal bundle between regs_dump, the register file's second read port and the dump consumer.
interface regs_dump_if;
  logic        start;
  logic [4:0]  dumpReg;
  logic [31:0] dumpData;
  logic        outValid;
  logic        outReady;
  logic [4:0]  outIndex;
  logic [31:0] outData;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [2:0]  dbgState;

  modport master (
    input  start, dumpData, outReady,
    output dumpReg, outValid, outIndex, outData, busy, done, checksum, dbgState
  );

  modport slave (
    output start, dumpData, outReady,
    input  dumpReg, outValid, outIndex, outData, busy, done, checksum, dbgState
  );
endinterface

// File: rtl/regs_dump.sv
// Walks register indices FIRST_REG..LAST_REG through the register file's second read port
// and streams each captured value with its index, finishing with a 32-bit checksum and a done pulse.
module regs_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic         clock,
  input  logic         reset,
  regs_dump_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  out_index_q, out_index_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] checksum_q, checksum_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q       <= FIRST_IDX;
      out_index_q <= 5'd0;
      out_data_q  <= 32'd0;
      checksum_q  <= 32'd0;
    end else begin
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
    end
  end

  // Stream handshake: a value transfers on a rising edge where outValid && outReady;
  // outValid is decoded from the state register only, and outIndex/outData hold until then.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ADDR;
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  state_d = S_OUT;
      S_OUT:   if (bus.outReady) state_d = (idx_q == LAST_IDX) ? S_DONE : S_ADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    case (state_q)
      S_IDLE: begin
        idx_d = FIRST_IDX;
        if (bus.start) checksum_d = 32'd0;
      end
      S_WAIT: begin
        out_data_d  = bus.dumpData;
        out_index_d = idx_q;
        checksum_d  = checksum_q + bus.dumpData;
      end
      // The last index exits to DONE without incrementing, so idx never wraps.
      S_OUT: begin
        if (bus.outReady && (idx_q != LAST_IDX)) idx_d = idx_q + 5'd1;
      end
      S_DONE: idx_d = FIRST_IDX;
      default: ;
    endcase
  end

  assign bus.dumpReg  = idx_q;
  assign bus.outValid = (state_q == S_OUT);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.outIndex = out_index_q;
  assign bus.outData  = out_data_q;
  assign bus.checksum = checksum_q;
  assign bus.dbgState = state_q;

endmodule
